// File: rtl/wb_rr_bridge.sv
// wb_rr_bridge: N-master to 1-slave Wishbone classic bridge.
// A round-robin arbiter picks one requesting master in IDLE. The grant is then
// held for as long as that master keeps its cyc asserted. Control, address and
// data are routed combinationally to the slave, and the slave's ack, err and
// read data are routed back to the granted master only.
// Optional feature: define WB_BRIDGE_WATCHDOG_EN to terminate cycles that
// stall for TIMEOUT_CYCLES clocks with a one-clock error pulse.
module wb_rr_bridge #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                 m_stb_i,
    input  logic [NUM_MASTERS-1:0]                 m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_dat_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_sel_i,
    output logic [NUM_MASTERS-1:0]                 m_ack_o,
    output logic [NUM_MASTERS-1:0]                 m_err_o,
    output logic [DATA_WIDTH-1:0]                  m_dat_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    output logic                                   s_we_o,
    output logic [ADDR_WIDTH-1:0]                  s_adr_o,
    output logic [DATA_WIDTH-1:0]                  s_dat_o,
    output logic [DATA_WIDTH/8-1:0]                s_sel_o,
    input  logic                                   s_ack_i,
    input  logic                                   s_err_i,
    input  logic [DATA_WIDTH-1:0]                  s_dat_i,
    output logic [$clog2(NUM_MASTERS)-1:0]         gnt_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int GNT_WIDTH = $clog2(NUM_MASTERS);
    localparam logic [GNT_WIDTH-1:0] LAST_IDX = GNT_WIDTH'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [GNT_WIDTH-1:0] gnt;
    logic [GNT_WIDTH-1:0] last_gnt;
    logic [GNT_WIDTH-1:0] next_gnt;
    logic [GNT_WIDTH-1:0] cand;
    logic                 found;
    logic                 any_req;
    logic                 busy;
    logic                 timeout;

    assign busy    = (state == BUSY);
    assign any_req = |m_cyc_i;
    assign gnt_o   = gnt;

    // Round-robin search: first requester strictly after last_gnt, wrapping.
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves a value held (which would be a latch).
    always_comb begin
        next_gnt = last_gnt;
        cand     = last_gnt;
        found    = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = GNT_WIDTH'((int'(last_gnt) + i) % NUM_MASTERS);
            if (!found && m_cyc_i[cand]) begin
                next_gnt = cand;
                found    = 1'b1;
            end
        end
    end

    // Next-state logic: grant on any request, release when the owner drops cyc.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (!m_cyc_i[gnt]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= LAST_IDX;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                gnt <= next_gnt;
            end
            if (state == BUSY && !m_cyc_i[gnt]) begin
                last_gnt <= gnt;
            end
        end
    end

`ifdef WB_BRIDGE_WATCHDOG_EN
    logic [7:0] wd_cnt;

    assign timeout = busy && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Stall counter: counts strobed clocks with no slave response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (!busy || timeout || !s_stb_o || s_ack_i || s_err_i) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Slave-side mux and master-side response demux, active only in BUSY.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (busy) begin
            s_cyc_o = m_cyc_i[gnt];
            s_stb_o = m_stb_i[gnt] && !timeout;
            s_we_o  = m_we_i[gnt];
            s_adr_o = m_adr_i[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o = m_dat_i[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            s_sel_o = m_sel_i[int'(gnt)*SEL_WIDTH +: SEL_WIDTH];
            // Error has priority over ack; a watchdog expiry is reported as error.
            if (timeout || s_err_i) begin
                m_err_o[gnt] = 1'b1;
            end else if (s_ack_i) begin
                m_ack_o[gnt] = 1'b1;
            end
            if (s_ack_i && !timeout) begin
                m_dat_o = s_dat_i;
            end
        end
    end

endmodule

// File: doc/wb_rr_bridge.md
# wb_rr_bridge

Parametrised N-master to 1-slave Wishbone classic bridge that sits between the bench's master interfaces and the DUT-side slave interface. It arbitrates round-robin among `NUM_MASTERS` requesters, routes the granted master's cycle to the single slave port, and returns ack/err/read data only to the granted master. An optional watchdog terminates stalled cycles with an error.

## Interface
- `NUM_MASTERS`, 2: number of master channels, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width, a multiple of 8.
- `TIMEOUT_CYCLES`, 16: watchdog limit in clocks, 2..255; used only with the watchdog compiled in.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `m_cyc_i` in NUM_MASTERS: per-master cycle request.
- `m_stb_i` in NUM_MASTERS: per-master strobe.
- `m_we_i` in NUM_MASTERS: per-master write enable.
- `m_adr_i` in NUM_MASTERS*ADDR_WIDTH: packed addresses; master k occupies slice k.
- `m_dat_i` in NUM_MASTERS*DATA_WIDTH: packed write data.
- `m_sel_i` in NUM_MASTERS*DATA_WIDTH/8: packed byte selects.
- `m_ack_o` out NUM_MASTERS: per-master acknowledge.
- `m_err_o` out NUM_MASTERS: per-master error.
- `m_dat_o` out DATA_WIDTH: read data, valid only with the granted master's ack.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: slave controls.
- `s_adr_o` out ADDR_WIDTH, `s_dat_o` out DATA_WIDTH, `s_sel_o` out DATA_WIDTH/8: slave address, write data, and byte selects.
- `s_ack_i`, `s_err_i` in 1 each; `s_dat_i` in DATA_WIDTH: slave responses.
- `gnt_o` out $clog2(NUM_MASTERS): current or last grant index, for debug.

## Operation
- FSM has two states, IDLE and BUSY.
- **IDLE:** all `s_*_o` are 0. If any `m_cyc_i` is high, the next clock registers `gnt` as the first requesting index searching upward from `last_gnt+1`, with wrap-around, and moves to BUSY.
- **BUSY:** `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o`, and `s_sel_o` mirror the granted master combinationally.
  - `s_ack_i` and `s_err_i` route combinationally to bit `gnt` of `m_ack_o` and `m_err_o`. All other bits are 0.
  - `m_dat_o` = `s_dat_i` while `s_ack_i` is high, otherwise 0.
- **Grant lock:** the grant holds across multiple strobes while the granted `m_cyc_i` stays high, so block and RMW cycles are never split.
- **Release:** when the granted `m_cyc_i` is low in BUSY, the next clock sets `last_gnt <= gnt` and returns to IDLE. Slave outputs drop in that same (combinational) cycle.
- **Request changes:** requests from other masters while BUSY are ignored. Masters that drop `m_cyc_i` before grant lose nothing.
- **Simultaneous ack and err from the slave:** err wins. The master sees `m_err_o`=1 and `m_ack_o`=0.

## Timing
- **Reset values:**
  - `gnt` = 0
  - `last_gnt` = NUM_MASTERS-1, so master 0 wins the first arbitration
  - state = IDLE
  - watchdog count = 0
  - all outputs 0
- **Reset mid-cycle:** outputs clear asynchronously, with no ack or err to any master.
- **Latency:**
  - request to `s_cyc_o`: 1 clock
  - slave ack to master ack: 0 clocks (combinational)
  - release to next grant: 1 IDLE clock minimum, so there are 2 clocks between back-to-back masters
- **Wrap-around:** after master NUM_MASTERS-1 is served, search resumes at 0.

## Configuration
- **`WB_BRIDGE_WATCHDOG_EN` defined:** an 8-bit counter increments each BUSY clock in which `s_stb_o` is high and neither `s_ack_i` nor `s_err_i` is high.
  - It clears on ack, err, strobe low, or leaving BUSY.
  - On the clock where the count equals TIMEOUT_CYCLES-1, `m_err_o[gnt]` pulses for 1 clock. `s_stb_o` is forced to 0 during that clock, and the counter clears.
  - The grant is retained; the master decides whether to drop `m_cyc_i`.
- **Undefined:** there is no counter, and a stalled slave hangs the granted master indefinitely.

## Test plan
- **Single write:** master 0 writes adr 0x10, data 0xDEADBEEF, sel 0xF. The slave acks after 2 clocks. Required: `s_cyc_o` is high 1 clock after request, `m_ack_o`=2'b01 for one clock, and `gnt_o`=0.
- **Simultaneous request:** masters 0 and 1 assert cyc in the same clock after reset. Required: master 0 is served first. After master 0 drops cyc, master 1 is granted 2 clocks later.
- **Fairness:** with NUM_MASTERS=4, all masters request continuously with single-beat cycles. Required: grants are issued in order 0,1,2,3,0; no master is ever granted twice in a row.
- **Read and err passthrough:** master 1 reads 0x20 and the slave returns 0xA5A5A5A5 with ack; the data appears on `m_dat_o`. In a second cycle the slave asserts ack and err together. Required: `m_err_o`=2'b10 and `m_ack_o`=0.
- **Watchdog (macro on, TIMEOUT_CYCLES=4):** the slave never acks. Required: `m_err_o[gnt]` pulses on the 4th stalled clock with `s_stb_o` low in that clock. Without the macro, no err appears within 100 clocks.
- **Reset mid-cycle:** `rst` is asserted while BUSY. Required: all outputs are 0 in the same clock. After release, master 0 wins the first arbitration.
